store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 20 ++
 rtl/store_buffer_if.sv | 27 ++
 rtl/store_buffer_fifo.sv | 70 +++++++
 rtl/store_buffer.sv | 102 ++++++++++
 tb/tb_store_buffer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: widths, halt address, enable
// levels and the buffered entry layout.
package store_buffer_pkg;

   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 32;
   localparam int WADDR_W = 16;

   localparam logic [ADDR_W-1:0] HALT_ADDR_DEF = 32'h0000_7fff;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   // One buffered store: dmem word address (byte address [17:2]) and data.
   typedef struct packed {
      logic [WADDR_W-1:0] waddr;
      logic [DATA_W-1:0]  data;
   } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// CPU-side and dmem-side signals of the store buffer.
// master = CPU/memory environment, slave = store buffer.
interface store_buffer_if;
   import store_buffer_pkg::*;

   logic [ADDR_W-1:0]  cpu_addr;
   logic [DATA_W-1:0]  cpu_wdata;
   logic               cpu_we;
   logic               cpu_re;
   logic [DATA_W-1:0]  cpu_rdata;
   logic               sb_stall;
   logic [WADDR_W-1:0] mem_a;
   logic [DATA_W-1:0]  mem_wd;
   logic               mem_we;
   logic [DATA_W-1:0]  mem_rd;

   modport master (
      output cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_rd,
      input  cpu_rdata, sb_stall, mem_a, mem_wd, mem_we
   );

   modport slave (
      input  cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_rd,
      output cpu_rdata, sb_stall, mem_a, mem_wd, mem_we
   );

endinterface

// File: rtl/store_buffer_fifo.sv
// Store buffer storage: circular FIFO with occupancy count and a
// youngest-match search over the valid entries for load forwarding.
module store_buffer_fifo
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  sb_entry_t                push_entry,
   input  logic                     pop,
   input  logic [WADDR_W-1:0]       fwd_waddr,
   output logic                     fwd_hit,
   output logic [DATA_W-1:0]        fwd_data,
   output sb_entry_t                head_entry,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] head_ptr;
   logic [PTR_W-1:0] tail_ptr;
   logic [PTR_W-1:0] idx;
   sb_entry_t        entries [DEPTH];

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else begin
         if (push) tail_ptr <= tail_ptr + PTR_W'(1);
         if (pop)  head_ptr <= head_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents need no reset because count marks validity.
   always_ff @(posedge clk) begin
      if (push) entries[tail_ptr] <= push_entry;
   end

   // Walk oldest to youngest so the last hit is the youngest matching store.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      idx      = head_ptr;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_ptr + PTR_W'(i);
         if ((CNT_W'(i) < count) && (entries[idx].waddr == fwd_waddr)) begin
            fwd_hit  = 1'b1;
            fwd_data = entries[idx].data;
         end
      end
   end

   assign head_entry = entries[head_ptr];
   assign full       = (count == CNT_W'(DEPTH));
   assign empty      = (count == '0);

endmodule

// File: rtl/store_buffer.sv
// Store buffer between CPU and dmem: queues stores, drains them when the
// CPU is not loading, forwards buffered data to loads, and tracks program
// end via a store to the halt address.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | normal operation, stores accepted
// ST_DRAIN | halt store seen, new stores ignored, buffer emptying
// ST_DONE  | buffer empty after halt, done held until reset
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int                DEPTH     = 4,
   parameter logic [ADDR_W-1:0] HALT_ADDR = HALT_ADDR_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   store_buffer_if.slave          sb,
   output logic [$clog2(DEPTH):0] count,
   output logic                   done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } halt_state_t;

   halt_state_t        state;
   logic               is_halt;
   logic               accepting;
   logic               push;
   logic               pop;
   logic               full;
   logic               empty;
   logic               fwd_hit;
   logic [DATA_W-1:0]  fwd_data;
   sb_entry_t          push_entry;
   sb_entry_t          head_entry;

   assign is_halt   = (sb.cpu_addr == HALT_ADDR);
   assign accepting = (state == ST_IDLE);

   // Full is judged on the count at cycle start; a same-cycle drain does not free a slot.
   assign push = ~rst & sb.cpu_we & accepting & ~is_halt & ~full;
   assign pop  = ~rst & ~sb.cpu_re & ~empty;

   assign push_entry = '{waddr: sb.cpu_addr[17:2], data: sb.cpu_wdata};

   store_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .fwd_waddr  (sb.cpu_addr[17:2]),
      .fwd_hit    (fwd_hit),
      .fwd_data   (fwd_data),
      .head_entry (head_entry),
      .count      (count),
      .full       (full),
      .empty      (empty)
   );

   // Loads own the dmem port; otherwise the head entry is presented for drain.
   always_comb begin
      sb.sb_stall  = ~rst & sb.cpu_we & accepting & ~is_halt & full;
      sb.mem_we    = pop ? ENABLE : DISABLE;
      sb.mem_a     = sb.cpu_re ? sb.cpu_addr[17:2] : head_entry.waddr;
      sb.mem_wd    = head_entry.data;
      sb.cpu_rdata = (~rst & fwd_hit) ? fwd_data : sb.mem_rd;
   end

   // Halt sequencing with registered done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         done  <= DISABLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (sb.cpu_we && is_halt) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (empty) begin
                  state <= ST_DONE;
                  done  <= ENABLE;
               end
            end
            ST_DONE: begin
               state <= ST_DONE;
               done  <= ENABLE;
            end
            default: begin
               state <= ST_IDLE;
               done  <= DISABLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: a queue-based reference model checked on every
// cycle, plus directed scenarios with literal expected values.
module tb_store_buffer;
   import store_buffer_pkg::*;

   localparam int          DEPTH = 4;
   localparam logic [31:0] HALT  = 32'h0000_7fff;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] count;
   logic       done;

   store_buffer_if sbif();

   store_buffer #(.DEPTH(DEPTH), .HALT_ADDR(HALT)) dut (
      .clk   (clk),
      .rst   (rst),
      .sb    (sbif.slave),
      .count (count),
      .done  (done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int writes_total = 0;
   logic model_on = 1'b0;

   logic [31:0] dmem    [0:255];
   logic [31:0] ref_mem [0:255];

   assign sbif.mem_rd = dmem[sbif.mem_a[7:0]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // dmem environment: preloaded during startup, then written by the DUT.
   always @(posedge clk) begin
      if (!model_on) begin
         for (int i = 0; i < 256; i++) dmem[i] <= 32'hC0DE_0000 | 32'(i);
      end else if (sbif.mem_we === 1'b1) begin
         dmem[sbif.mem_a[7:0]] <= sbif.mem_wd;
         writes_total <= writes_total + 1;
      end
   end

   // Reference model: program-order queue of pending stores and halt flags.
   logic [15:0] mq_a [$];
   logic [31:0] mq_d [$];
   logic        m_halt, m_done;
   logic        e_stall, e_we, full, is_halt, active, nd;
   logic [15:0] wa;
   logic [31:0] e_rd;

   always @(negedge clk) begin
      if (!model_on) begin
         for (int i = 0; i < 256; i++) ref_mem[i] = 32'hC0DE_0000 | 32'(i);
         mq_a.delete();
         mq_d.delete();
         m_halt = 1'b0;
         m_done = 1'b0;
      end else begin
         wa      = sbif.cpu_addr[17:2];
         full    = (mq_a.size() == DEPTH);
         is_halt = (sbif.cpu_addr == HALT);
         active  = !m_halt && !m_done;
         if (rst) begin
            e_stall = 1'b0;
            e_we    = 1'b0;
         end else begin
            e_stall = sbif.cpu_we && full && !is_halt && active;
            e_we    = !sbif.cpu_re && (mq_a.size() > 0);
         end
         chk("sb_stall", 32'(sbif.sb_stall), 32'(e_stall));
         chk("mem_we", 32'(sbif.mem_we), 32'(e_we));
         if (e_we) begin
            chk("drain mem_a", 32'(sbif.mem_a), 32'(mq_a[0]));
            chk("drain mem_wd", sbif.mem_wd, mq_d[0]);
         end
         if (sbif.cpu_re) begin
            chk("load mem_a", 32'(sbif.mem_a), 32'(wa));
            e_rd = ref_mem[wa[7:0]];
            if (!rst)
               for (int i = 0; i < mq_a.size(); i++)
                  if (mq_a[i] == wa) e_rd = mq_d[i];
            chk("cpu_rdata", sbif.cpu_rdata, e_rd);
         end
         chk("count", 32'(count), 32'(mq_a.size()));
         chk("done", 32'(done), 32'(m_done));

         if (rst) begin
            mq_a.delete();
            mq_d.delete();
            m_halt = 1'b0;
            m_done = 1'b0;
         end else begin
            nd = m_done || (m_halt && mq_a.size() == 0);
            if (e_we) begin
               ref_mem[mq_a[0][7:0]] = mq_d[0];
               void'(mq_a.pop_front());
               void'(mq_d.pop_front());
            end
            if (sbif.cpu_we && active && !full && !is_halt) begin
               mq_a.push_back(wa);
               mq_d.push_back(sbif.cpu_wdata);
            end
            if (sbif.cpu_we && active && is_halt) m_halt = 1'b1;
            m_done = nd;
         end
      end
   end

   task automatic drive(input logic r, input logic we, input logic re,
                        input logic [31:0] a, input logic [31:0] d);
      rst            = r;
      sbif.cpu_we    = we;
      sbif.cpu_re    = re;
      sbif.cpu_addr  = a;
      sbif.cpu_wdata = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int zc, dc, w0;

   initial begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      tick(); tick(); tick();
      model_on = 1'b1;
      tick();

      // single store drains on the next cycle
      drive(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      chk("single mem_we", 32'(sbif.mem_we), 32'd1);
      chk("single mem_a", 32'(sbif.mem_a), 32'd4);
      chk("single mem_wd", sbif.mem_wd, 32'hDEAD_BEEF);
      tick();
      chk("single count", 32'(count), 32'd0);
      chk("single dmem", dmem[4], 32'hDEAD_BEEF);

      // fill while loads block drain, fifth store stalls
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 1'b1, 32'h200 + 32'(4 * i), 32'hA0 + 32'(i));
         tick();
      end
      drive(1'b0, 1'b1, 1'b1, 32'h210, 32'hA4);
      #1;
      chk("fill stall", 32'(sbif.sb_stall), 32'd1);
      chk("fill count", 32'(count), 32'd4);
      tick();
      chk("fill count held", 32'(count), 32'd4);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("fill drain we", 32'(sbif.mem_we), 32'd1);
         chk("fill drain a", 32'(sbif.mem_a), 32'h80 + 32'(i));
         chk("fill drain wd", sbif.mem_wd, 32'hA0 + 32'(i));
         tick();
      end
      chk("fill empty", 32'(count), 32'd0);

      // forwarding of the youngest store over stale memory
      drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h1);
      tick();
      drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h2);
      tick();
      drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h0);
      #1;
      chk("fwd rdata", sbif.cpu_rdata, 32'h2);
      chk("fwd mem old", dmem[8], 32'hC0DE_0008);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick(); tick(); tick();
      chk("fwd mem final", dmem[8], 32'h2);

      // ten stores with interleaved loads, pointers wrap
      w0 = writes_total;
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i));
         tick();
         if (i % 3 == 2) begin
            drive(1'b0, 1'b0, 1'b1, 32'h100 + 32'(4 * i), 32'h0);
            #1;
            chk("wrap load", sbif.cpu_rdata, 32'h1000 + 32'(i));
            tick();
         end
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 6; i++) tick();
      chk("wrap writes", 32'(writes_total - w0), 32'd10);
      for (int i = 0; i < 10; i++)
         chk("wrap dmem", dmem[8'h40 + i], 32'h1000 + 32'(i));

      // halt after three buffered stores
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 1'b1, 32'h300 + 32'(4 * i), 32'h3000 + 32'(i));
         tick();
      end
      drive(1'b0, 1'b1, 1'b1, HALT, 32'h5555);
      #1;
      chk("halt stall", 32'(sbif.sb_stall), 32'd0);
      tick();
      chk("halt count", 32'(count), 32'd3);
      chk("halt done early", 32'(done), 32'd0);
      zc = -1;
      dc = -1;
      for (int c = 0; c < 16; c++) begin
         drive(1'b0, c[0], 1'b0, 32'h340, 32'h7777);
         tick();
         if (count == 0 && zc < 0) zc = c;
         if (done && dc < 0) dc = c;
      end
      chk("halt zero cycle", 32'(zc), 32'd2);
      chk("halt done lag", 32'(dc - zc), 32'd1);
      chk("halt done", 32'(done), 32'd1);
      chk("halt count0", 32'(count), 32'd0);
      chk("halt dmem", dmem[8'hC2], 32'h3002);
      chk("halt ignored", dmem[8'hD0], 32'hC0DE_00D0);

      // reset discards buffered stores
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 1'b1, 32'h380 + 32'(4 * i), 32'h8000 + 32'(i));
         tick();
      end
      chk("rst pre count", 32'(count), 32'd3);
      w0 = writes_total;
      drive(1'b1, 1'b0, 1'b1, 32'h380, 32'h0);
      #1;
      chk("rst mem_we", 32'(sbif.mem_we), 32'd0);
      chk("rst rdata", sbif.cpu_rdata, 32'hC0DE_00E0);
      tick();
      chk("rst count", 32'(count), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick(); tick();
      chk("rst no writes", 32'(writes_total - w0), 32'd0);
      chk("rst dmem", dmem[8'hE0], 32'hC0DE_00E0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
